fb_slave_databuf: RTL and testbench

//  Ping-pong byte buffer between the FreedM-bus slave MAC and the local host logic, all on MRxClk.
//  Rx side: captures MAC RxData/RxValid/RxRamAddr into a shadow bank, then publishes it to the host only when the frame ends CRC-clean.
//  Tx side: host stages bytes in a pending bank, and they are handed to the MAC at the next frame start.
//  The MAC therefore always reads a stable bank through TxRamAddr/TxData, and the host always sees one whole frame.

---
 rtl/fb_slave_databuf.sv | 178 +++++++++++++++++
 tb/tb_fb_slave_databuf.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_slave_databuf.sv
// rtl/fb_slave_databuf.sv - ping-pong rx/tx byte buffer between FreedM-bus slave MAC and host
// Purpose: the MAC writes rx bytes into a shadow bank. That bank is handed to the host only when
//   the frame ends CRC-clean. The host stages tx bytes in a pending bank, which is swapped in at
//   the next frame start.
// Ports: MRxClk/Reset_n clock and async active-low reset; FrameBusy/FrameCrcErr/RxValid/RxRamAddr/
//   RxData MAC rx side; TxRamAddr/TxData MAC tx side; HostWrEn/HostAddr/HostWrData/HostTxCommit host
//   tx staging; HostRdEn/HostRdData/HostRdValid host rx readback; TxPending/RxFrameReady/
//   RxFrameDrop/RxByteCnt status.
// Option: FB_DATABUF_STATS_EN adds RxGoodCnt/RxDropCnt frame counters.
module fb_slave_databuf #(
    parameter int AW = 4
) (
    input  logic          MRxClk,
    input  logic          Reset_n,
    input  logic          FrameBusy,
    input  logic          FrameCrcErr,
    input  logic          RxValid,
    input  logic [7:0]    RxRamAddr,
    input  logic [7:0]    RxData,
    input  logic [7:0]    TxRamAddr,
    output logic [7:0]    TxData,
    input  logic          HostWrEn,
    input  logic [AW-1:0] HostAddr,
    input  logic [7:0]    HostWrData,
    input  logic          HostTxCommit,
    input  logic          HostRdEn,
    output logic [7:0]    HostRdData,
    output logic          HostRdValid,
    output logic          TxPending,
    output logic          RxFrameReady,
    output logic          RxFrameDrop,
`ifdef FB_DATABUF_STATS_EN
    output logic [15:0]   RxGoodCnt,
    output logic [15:0]   RxDropCnt,
`endif
    output logic [AW:0]   RxByteCnt
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_COMMIT} state_t;

    state_t        state_q, state_d;
    logic          rx_bank_sel_q, rx_bank_sel_d;
    logic          tx_bank_sel_q, tx_bank_sel_d;
    logic          tx_pending_q, tx_pending_d;
    logic          err_sticky_q, err_sticky_d;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;
    logic [AW:0]   rx_byte_cnt_q, rx_byte_cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    host_rd_data_q, host_rd_data_d;
    logic          host_rd_valid_q, host_rd_valid_d;

    logic          frame_start;
    logic          rx_wr;
    logic          publish;
    logic          drop;

    // Bank index is the MSB of each RAM address: {bank, byte}.
    logic [7:0]    rx_mem [0:2*DEPTH-1];
    logic [7:0]    tx_mem [0:2*DEPTH-1];

    always_comb begin
        state_d         = state_q;
        rx_bank_sel_d   = rx_bank_sel_q;
        tx_bank_sel_d   = tx_bank_sel_q;
        tx_pending_d    = tx_pending_q;
        err_sticky_d    = err_sticky_q;
        rx_cnt_d        = rx_cnt_q;
        rx_byte_cnt_d   = rx_byte_cnt_q;

        frame_start = (state_q == S_IDLE) && FrameBusy;
        // Out-of-range rx bytes are dropped silently; they do not fail the frame.
        rx_wr       = (state_q == S_ACTIVE) && RxValid && ((RxRamAddr >> AW) == 8'd0);
        publish     = (state_q == S_COMMIT) && !err_sticky_q && (rx_cnt_q != '0);
        drop        = (state_q == S_COMMIT) && !publish;

        case (state_q)
            S_IDLE:   if (FrameBusy) state_d = S_ACTIVE;
            S_ACTIVE: if (!FrameBusy) state_d = S_COMMIT;
            default:  state_d = S_IDLE;
        endcase

        if (frame_start) begin
            rx_cnt_d     = '0;
            err_sticky_d = 1'b0;
        end

        // Swap decision uses the registered pending flag, so a commit landing
        // on the start cycle waits for the following frame.
        if (frame_start && tx_pending_q) begin
            tx_bank_sel_d = ~tx_bank_sel_q;
            tx_pending_d  = 1'b0;
        end else if (HostTxCommit) begin
            tx_pending_d  = 1'b1;
        end

        if (state_q == S_ACTIVE) begin
            if (FrameCrcErr) err_sticky_d = 1'b1;
            if (rx_wr && (rx_cnt_q < DEPTH_W)) rx_cnt_d = rx_cnt_q + 1'b1;
        end

        if (publish) begin
            rx_bank_sel_d = ~rx_bank_sel_q;
            rx_byte_cnt_d = rx_cnt_q;
        end

        tx_data_d       = ((TxRamAddr >> AW) == 8'd0) ?
                          tx_mem[{tx_bank_sel_q, TxRamAddr[AW-1:0]}] : 8'h00;
        host_rd_valid_d = HostRdEn;
        host_rd_data_d  = HostRdEn ? rx_mem[{~rx_bank_sel_q, HostAddr}] : host_rd_data_q;
    end

    always_ff @(posedge MRxClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q         <= S_IDLE;
            rx_bank_sel_q   <= 1'b0;
            tx_bank_sel_q   <= 1'b0;
            tx_pending_q    <= 1'b0;
            err_sticky_q    <= 1'b0;
            rx_cnt_q        <= '0;
            rx_byte_cnt_q   <= '0;
            tx_data_q       <= 8'h00;
            host_rd_data_q  <= 8'h00;
            host_rd_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rx_bank_sel_q   <= rx_bank_sel_d;
            tx_bank_sel_q   <= tx_bank_sel_d;
            tx_pending_q    <= tx_pending_d;
            err_sticky_q    <= err_sticky_d;
            rx_cnt_q        <= rx_cnt_d;
            rx_byte_cnt_q   <= rx_byte_cnt_d;
            tx_data_q       <= tx_data_d;
            host_rd_data_q  <= host_rd_data_d;
            host_rd_valid_q <= host_rd_valid_d;
        end
    end

    // MAC always touches the shadow rx / active tx bank, host the opposite one.
    always_ff @(posedge MRxClk) begin
        if (rx_wr) rx_mem[{rx_bank_sel_q, RxRamAddr[AW-1:0]}] <= RxData;
        if (HostWrEn) tx_mem[{~tx_bank_sel_q, HostAddr}] <= HostWrData;
    end

    assign TxData       = tx_data_q;
    assign HostRdData   = host_rd_data_q;
    assign HostRdValid  = host_rd_valid_q;
    assign TxPending    = tx_pending_q;
    assign RxFrameReady = publish;
    assign RxFrameDrop  = drop;
    assign RxByteCnt    = rx_byte_cnt_q;

`ifdef FB_DATABUF_STATS_EN
    logic [15:0] rx_good_cnt_q, rx_good_cnt_d;
    logic [15:0] rx_drop_cnt_q, rx_drop_cnt_d;

    always_comb begin
        rx_good_cnt_d = rx_good_cnt_q;
        rx_drop_cnt_d = rx_drop_cnt_q;
        if (publish) rx_good_cnt_d = rx_good_cnt_q + 16'd1;
        if (drop)    rx_drop_cnt_d = rx_drop_cnt_q + 16'd1;
    end

    always_ff @(posedge MRxClk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_good_cnt_q <= 16'd0;
            rx_drop_cnt_q <= 16'd0;
        end else begin
            rx_good_cnt_q <= rx_good_cnt_d;
            rx_drop_cnt_q <= rx_drop_cnt_d;
        end
    end

    assign RxGoodCnt = rx_good_cnt_q;
    assign RxDropCnt = rx_drop_cnt_q;
`endif
endmodule

// File: tb/tb_fb_slave_databuf.sv
// tb/tb_fb_slave_databuf.sv - directed self-checking bench for fb_slave_databuf
module tb_fb_slave_databuf;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_busy = 1'b0;
    logic          frame_crc_err = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_ram_addr = 8'h00;
    logic [7:0]    rx_data = 8'h00;
    logic [7:0]    tx_ram_addr = 8'h00;
    logic [7:0]    tx_data;
    logic          host_wr_en = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [7:0]    host_wr_data = 8'h00;
    logic          host_tx_commit = 1'b0;
    logic          host_rd_en = 1'b0;
    logic [7:0]    host_rd_data;
    logic          host_rd_valid;
    logic          tx_pending;
    logic          rx_frame_ready;
    logic          rx_frame_drop;
    logic [AW:0]   rx_byte_cnt;
`ifdef FB_DATABUF_STATS_EN
    logic [15:0]   rx_good_cnt;
    logic [15:0]   rx_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_slave_databuf #(.AW(AW)) dut (
        .MRxClk(clk),
        .Reset_n(rst_n),
        .FrameBusy(frame_busy),
        .FrameCrcErr(frame_crc_err),
        .RxValid(rx_valid),
        .RxRamAddr(rx_ram_addr),
        .RxData(rx_data),
        .TxRamAddr(tx_ram_addr),
        .TxData(tx_data),
        .HostWrEn(host_wr_en),
        .HostAddr(host_addr),
        .HostWrData(host_wr_data),
        .HostTxCommit(host_tx_commit),
        .HostRdEn(host_rd_en),
        .HostRdData(host_rd_data),
        .HostRdValid(host_rd_valid),
        .TxPending(tx_pending),
        .RxFrameReady(rx_frame_ready),
        .RxFrameDrop(rx_frame_drop),
`ifdef FB_DATABUF_STATS_EN
        .RxGoodCnt(rx_good_cnt),
        .RxDropCnt(rx_drop_cnt),
`endif
        .RxByteCnt(rx_byte_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_read(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
        host_rd_en = 1'b1;
        host_addr  = a;
        step();
        host_rd_en = 1'b0;
        checks++;
        if (host_rd_valid !== 1'b1 || host_rd_data !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%h, expected valid=1 data=%h", name, host_rd_valid, host_rd_data, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({tx_data, host_rd_data, host_rd_valid, tx_pending, rx_frame_ready, rx_frame_drop, rx_byte_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got txd=%h rdd=%h rdv=%b pend=%b rdy=%b drp=%b cnt=%0d, expected all 0",
                     tx_data, host_rd_data, host_rd_valid, tx_pending, rx_frame_ready, rx_frame_drop, rx_byte_cnt);
        end
        host_rd_en = 1'b1;
        host_addr  = '0;
        step();
        host_rd_en = 1'b0;
        checks++;
        if (host_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdvalid: got %b, expected 1", host_rd_valid);
        end
        step();
        checks++;
        if (host_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdvalid_idle: got %b, expected 0", host_rd_valid);
        end
    endtask

    task automatic test_rx_good();
        frame_busy = 1'b1;
        step();
        rx_valid = 1'b1; rx_ram_addr = 8'd0; rx_data = 8'hA5;
        step();
        rx_ram_addr = 8'd1; rx_data = 8'h5A;
        step();
        rx_valid = 1'b0; frame_busy = 1'b0;
        step();
        checks++;
        if (rx_frame_ready !== 1'b1 || rx_frame_drop !== 1'b0) begin
            errors++;
            $display("FAIL good_pulse: got rdy=%b drp=%b, expected rdy=1 drp=0", rx_frame_ready, rx_frame_drop);
        end
        step();
        checks++;
        if (rx_byte_cnt !== 5'd2 || rx_frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL good_cnt: got cnt=%0d rdy=%b, expected cnt=2 rdy=0", rx_byte_cnt, rx_frame_ready);
        end
        host_read(4'd0, 8'hA5, "good_rd0");
        host_read(4'd1, 8'h5A, "good_rd1");
    endtask

    task automatic test_rx_crc_err();
        frame_busy = 1'b1;
        step();
        rx_valid = 1'b1; rx_ram_addr = 8'd0; rx_data = 8'h11;
        step();
        rx_ram_addr = 8'd1; rx_data = 8'h22; frame_crc_err = 1'b1;
        step();
        rx_ram_addr = 8'd2; rx_data = 8'h33; frame_crc_err = 1'b0;
        step();
        rx_valid = 1'b0; frame_busy = 1'b0;
        step();
        checks++;
        if (rx_frame_drop !== 1'b1 || rx_frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL crc_pulse: got rdy=%b drp=%b, expected rdy=0 drp=1", rx_frame_ready, rx_frame_drop);
        end
        step();
        checks++;
        if (rx_byte_cnt !== 5'd2) begin
            errors++;
            $display("FAIL crc_cnt: got %0d, expected 2", rx_byte_cnt);
        end
        host_read(4'd0, 8'hA5, "crc_rd0");
        host_read(4'd1, 8'h5A, "crc_rd1");
    endtask

    task automatic test_tx_commit();
        host_wr_en = 1'b1; host_addr = 4'd2; host_wr_data = 8'h3C;
        step();
        host_addr = 4'd3; host_wr_data = 8'h33;
        step();
        host_wr_en = 1'b0; host_tx_commit = 1'b1;
        step();
        host_tx_commit = 1'b0;
        checks++;
        if (tx_pending !== 1'b1) begin
            errors++;
            $display("FAIL tx_pend_set: got %b, expected 1", tx_pending);
        end
        frame_busy = 1'b1;
        step();
        checks++;
        if (tx_pending !== 1'b0) begin
            errors++;
            $display("FAIL tx_pend_clr: got %b, expected 0", tx_pending);
        end
        tx_ram_addr = 8'd2;
        step();
        checks++;
        if (tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL tx_data2: got %h, expected 3c", tx_data);
        end
        tx_ram_addr = 8'h12;
        step();
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL tx_data_oor: got %h, expected 00", tx_data);
        end
        frame_busy = 1'b0;
        step();
        checks++;
        if (rx_frame_drop !== 1'b1) begin
            errors++;
            $display("FAIL empty_drop: got %b, expected 1", rx_frame_drop);
        end
        step();
    endtask

    task automatic test_commit_on_start();
        host_wr_en = 1'b1; host_addr = 4'd3; host_wr_data = 8'h77;
        step();
        host_wr_en = 1'b0;
        frame_busy = 1'b1; host_tx_commit = 1'b1; tx_ram_addr = 8'd3;
        step();
        host_tx_commit = 1'b0;
        checks++;
        if (tx_pending !== 1'b1 || tx_data !== 8'h33) begin
            errors++;
            $display("FAIL start_commit: got pend=%b txd=%h, expected pend=1 txd=33", tx_pending, tx_data);
        end
        frame_busy = 1'b0;
        step();
        step();
        frame_busy = 1'b1;
        step();
        checks++;
        if (tx_pending !== 1'b0) begin
            errors++;
            $display("FAIL late_swap_pend: got %b, expected 0", tx_pending);
        end
        step();
        checks++;
        if (tx_data !== 8'h77) begin
            errors++;
            $display("FAIL late_swap_data: got %h, expected 77", tx_data);
        end
        frame_busy = 1'b0;
        step();
        step();
    endtask

    task automatic test_saturate();
        frame_busy = 1'b1;
        step();
        rx_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            rx_ram_addr = 8'(i % 16);
            rx_data     = 8'(i);
            step();
        end
        rx_valid = 1'b0; frame_busy = 1'b0;
        step();
        checks++;
        if (rx_frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_pulse: got %b, expected 1", rx_frame_ready);
        end
        step();
        checks++;
        if (rx_byte_cnt !== 5'd16) begin
            errors++;
            $display("FAIL sat_cnt: got %0d, expected 16", rx_byte_cnt);
        end
        host_read(4'd1, 8'h11, "sat_rd1");
        host_read(4'd5, 8'h05, "sat_rd5");
    endtask

    task automatic test_oor_and_reset();
        frame_busy = 1'b1;
        step();
        rx_valid = 1'b1; rx_ram_addr = 8'h40; rx_data = 8'hEE;
        step();
        rx_ram_addr = 8'd0; rx_data = 8'h99;
        step();
        rx_valid = 1'b0; frame_busy = 1'b0;
        step();
        checks++;
        if (rx_frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL oor_pulse: got %b, expected 1", rx_frame_ready);
        end
        step();
        checks++;
        if (rx_byte_cnt !== 5'd1) begin
            errors++;
            $display("FAIL oor_cnt: got %0d, expected 1", rx_byte_cnt);
        end
        host_read(4'd0, 8'h99, "oor_rd0");
        host_wr_en = 1'b1; host_addr = 4'd0; host_wr_data = 8'h55;
        step();
        host_wr_en = 1'b0; host_tx_commit = 1'b1;
        step();
        host_tx_commit = 1'b0;
        frame_busy = 1'b1; host_rd_en = 1'b1; host_addr = 4'd0;
        step();
        rx_valid = 1'b1; rx_ram_addr = 8'd4; rx_data = 8'hC3;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_data, host_rd_data, host_rd_valid, tx_pending, rx_frame_ready, rx_frame_drop, rx_byte_cnt} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got txd=%h rdd=%h rdv=%b pend=%b rdy=%b drp=%b cnt=%0d, expected all 0",
                     tx_data, host_rd_data, host_rd_valid, tx_pending, rx_frame_ready, rx_frame_drop, rx_byte_cnt);
        end
        rx_valid = 1'b0; frame_busy = 1'b0; host_rd_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (rx_frame_ready !== 1'b0 || rx_frame_drop !== 1'b0 || rx_byte_cnt !== 5'd0) begin
            errors++;
            $display("FAIL postreset_idle: got rdy=%b drp=%b cnt=%0d, expected 0 0 0", rx_frame_ready, rx_frame_drop, rx_byte_cnt);
        end
    endtask

`ifdef FB_DATABUF_STATS_EN
    task automatic test_stats_wrap();
        checks++;
        if (rx_good_cnt !== 16'd0 || rx_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset: got good=%0d drop=%0d, expected 0 0", rx_good_cnt, rx_drop_cnt);
        end
        for (int f = 0; f < 65536; f++) begin
            frame_busy = 1'b1;
            step();
            frame_busy = 1'b0; rx_valid = 1'b1; rx_ram_addr = 8'd0; rx_data = 8'h01;
            step();
            rx_valid = 1'b0;
            step();
            if (f == 0) begin
                checks++;
                if (rx_good_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL stats_first: got %0d, expected 1", rx_good_cnt);
                end
            end
        end
        checks++;
        if (rx_good_cnt !== 16'd0 || rx_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_wrap: got good=%0d drop=%0d, expected 0 0", rx_good_cnt, rx_drop_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rx_good();
        test_rx_crc_err();
        test_tx_commit();
        test_commit_on_start();
        test_saturate();
        test_oor_and_reset();
`ifdef FB_DATABUF_STATS_EN
        test_stats_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
